// File: rtl/reg_bank_reader_if.sv
// rtl/reg_bank_reader_if.sv - request, bank-strobe and result handshake signals of the register bank reader
interface reg_bank_reader_if #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2
) ();
  logic                 start;
  logic [ADDR_W-1:0]    addr;
  logic [WIDTH-1:0]     bus_in;
  logic [NUM_WORDS-1:0] word_sel;
  logic                 cell_load;
  logic                 cell_en;
  logic                 busy;
  logic [WIDTH-1:0]     data_out;
  logic                 valid;
  logic                 ready;
  logic                 err;

  modport master (
    output start, addr, bus_in, ready,
    input  word_sel, cell_load, cell_en, busy, data_out, valid, err
  );

  modport slave (
    input  start, addr, bus_in, ready,
    output word_sel, cell_load, cell_en, busy, data_out, valid, err
  );
endinterface

// File: rtl/reg_bank_reader.sv
// rtl/reg_bank_reader.sv - strobes one word of the cell bank, double-samples the read bus, returns the word
module reg_bank_reader #(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic             Clk,
  input  logic             Clear,
  reg_bank_reader_if.slave rb
);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [ADDR_W:0] NW_C = (ADDR_W+1)'(NUM_WORDS);

  typedef enum logic [2:0] {IDLE, SELECT, SAMPLE1, SAMPLE2, DONE} state_t;

  state_t               state, state_nx;
  logic [ADDR_W-1:0]    addr_q;
  logic [RW-1:0]        retry_q;
  logic [WIDTH-1:0]     s1_q;
  logic [WIDTH-1:0]     data_q;
  logic                 err_q;
  logic                 valid_q;
  logic [NUM_WORDS-1:0] sel_q;
  logic                 load_q;
  logic                 en_q;
  logic                 addr_ok;
  logic                 mismatch;
  logic                 retry_max;
  logic                 reading;

  assign addr_ok   = {1'b0, rb.addr} < NW_C;
  assign mismatch  = rb.bus_in != s1_q;
  assign retry_max = retry_q == RW'(MAX_RETRY);
  assign reading   = (state == SELECT) || (state == SAMPLE1) || (state == SAMPLE2);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rb.start) state_nx = addr_ok ? SELECT : DONE;
      SELECT:  state_nx = SAMPLE1;
      SAMPLE1: state_nx = SAMPLE2;
      SAMPLE2: state_nx = (!mismatch || retry_max) ? DONE : SELECT;
      DONE:    if (valid_q && rb.ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes and valid are registered from the current state, so the bank sees
  // them one cycle after the state change and the bus is sampled while they are up.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state   <= IDLE;
      addr_q  <= '0;
      retry_q <= '0;
      s1_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (rb.start) begin
            addr_q  <= rb.addr;
            retry_q <= '0;
            err_q   <= !addr_ok;
            if (!addr_ok) data_q <= '0;
          end
        end
        SAMPLE1: s1_q <= rb.bus_in;
        SAMPLE2: begin
          if (!mismatch || retry_max) begin
            data_q <= rb.bus_in;
            err_q  <= mismatch;
          end else begin
            retry_q <= retry_q + 1'b1;
          end
        end
        default: ;
      endcase
      sel_q   <= reading ? (NUM_WORDS'(1) << addr_q) : '0;
      load_q  <= state == SELECT;
      en_q    <= reading;
      valid_q <= (state == DONE) && !(valid_q && rb.ready);
    end
  end

  assign rb.word_sel  = sel_q;
  assign rb.cell_load = load_q;
  assign rb.cell_en   = en_q;
  assign rb.busy      = state != IDLE;
  assign rb.data_out  = data_q;
  assign rb.valid     = valid_q;
  assign rb.err       = valid_q & err_q;
endmodule

// File: tb/tb_reg_bank_reader.sv
// tb/tb_reg_bank_reader.sv - scoreboard bench for reg_bank_reader (4-word bank and 3-word bank instances)
module tb_reg_bank_reader;
  logic Clk = 1'b0;
  logic Clear;
  always #5 Clk = ~Clk;

  reg_bank_reader_if #(.WIDTH(8), .NUM_WORDS(4), .ADDR_W(2)) rb0 ();
  reg_bank_reader_if #(.WIDTH(8), .NUM_WORDS(3), .ADDR_W(2)) rb1 ();

  reg_bank_reader #(.WIDTH(8), .NUM_WORDS(4), .ADDR_W(2), .MAX_RETRY(3)) dut0 (
    .Clk(Clk), .Clear(Clear), .rb(rb0));
  reg_bank_reader #(.WIDTH(8), .NUM_WORDS(3), .ADDR_W(2), .MAX_RETRY(3)) dut1 (
    .Clk(Clk), .Clear(Clear), .rb(rb1));

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] bank [4];
  logic       bank_mode;
  logic [7:0] bus_force;

  // Bank model: the selected word drives the bus; otherwise a forced pattern
  always_comb begin
    rb0.bus_in = 8'h00;
    if (!bank_mode) rb0.bus_in = bus_force;
    else begin
      for (int i = 0; i < 4; i++)
        if (rb0.word_sel[i]) rb0.bus_in = bank[i];
    end
  end
  assign rb1.bus_in = 8'h00;

  always @(negedge Clk) begin
    n_cmp++;
    if (((rb0.cell_load | rb0.cell_en) && rb0.word_sel == 4'b0) || $countones(rb0.word_sel) > 1 ||
        ((rb1.cell_load | rb1.cell_en) && rb1.word_sel == 3'b0) || $countones(rb1.word_sel) > 1) begin
      n_bad++;
      $display("FAIL strobe_rule: sel0=%b load0=%b en0=%b sel1=%b load1=%b en1=%b required one-hot sel with strobes",
               rb0.word_sel, rb0.cell_load, rb0.cell_en, rb1.word_sel, rb1.cell_load, rb1.cell_en);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic e, input int lat);
    exp_t x;
    x.data = d; x.err = e; x.lat = lat;
    sb.push_back(x);
  endtask

  task automatic wait_valid0(input int budget, inout int k, output logic got);
    got = 1'b0;
    while (!got && k < budget) begin
      step(); k++;
      if (rb0.valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    step(); step();
    n_cmp++;
    if ({rb0.busy, rb0.valid, rb0.err, rb0.word_sel, rb0.cell_load, rb0.cell_en, rb0.data_out} !== 17'h0) begin
      n_bad++;
      $display("FAIL reset0: busy=%b valid=%b err=%b sel=%b load=%b en=%b data=%h required all 0",
               rb0.busy, rb0.valid, rb0.err, rb0.word_sel, rb0.cell_load, rb0.cell_en, rb0.data_out);
    end
    n_cmp++;
    if ({rb1.busy, rb1.valid, rb1.err, rb1.word_sel, rb1.data_out} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset1: busy=%b valid=%b err=%b sel=%b data=%h required all 0",
               rb1.busy, rb1.valid, rb1.err, rb1.word_sel, rb1.data_out);
    end
    Clear = 1'b0;
    step();
  endtask

  task automatic test_clean_read();
    int k; logic got; exp_t e;
    bank_mode = 1'b1; rb0.ready = 1'b1; rb0.addr = 2'd2; rb0.start = 1'b1;
    push_exp(8'hA5, 1'b0, 4);
    step(); rb0.start = 1'b0; k = 0;
    step(); k = 1;
    n_cmp++;
    if ({rb0.word_sel, rb0.cell_load, rb0.cell_en} !== 6'b0100_1_1) begin
      n_bad++;
      $display("FAIL clean_strobes: sel=%b load=%b en=%b required 0100 1 1", rb0.word_sel, rb0.cell_load, rb0.cell_en);
    end
    wait_valid0(20, k, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++; $display("FAIL clean_valid: no valid within 20 cycles, required valid at 4"); sb.delete();
    end else begin
      e = sb.pop_front();
      if ({rb0.data_out, rb0.err} !== {e.data, e.err} || k !== e.lat) begin
        n_bad++;
        $display("FAIL clean_result: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                 rb0.data_out, rb0.err, k, e.data, e.err, e.lat);
      end
    end
    step();
    n_cmp++;
    if ({rb0.valid, rb0.busy} !== 2'b00) begin
      n_bad++; $display("FAIL clean_release: valid=%b busy=%b required 0 0", rb0.valid, rb0.busy);
    end
  endtask

  task automatic test_backpressure();
    int k; logic got; exp_t e;
    bank_mode = 1'b1; rb0.ready = 1'b0; rb0.addr = 2'd2; rb0.start = 1'b1;
    push_exp(8'hA5, 1'b0, 4);
    step(); rb0.start = 1'b0; k = 0;
    wait_valid0(20, k, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++; $display("FAIL bp_valid: no valid within 20 cycles, required valid at 4"); sb.delete();
    end else begin
      e = sb.pop_front();
      if ({rb0.data_out, rb0.err} !== {e.data, e.err} || k !== e.lat) begin
        n_bad++;
        $display("FAIL bp_result: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                 rb0.data_out, rb0.err, k, e.data, e.err, e.lat);
      end
      while (k < 10) begin
        n_cmp++;
        if ({rb0.valid, rb0.data_out} !== {1'b1, 8'hA5}) begin
          n_bad++; $display("FAIL bp_hold@%0d: valid=%b data=%h required 1 a5", k, rb0.valid, rb0.data_out);
        end
        if (k == 5) begin rb0.start = 1'b1; rb0.addr = 2'd1; end
        if (k == 6) rb0.start = 1'b0;
        if (k == 9) rb0.ready = 1'b1;
        step(); k++;
      end
      n_cmp++;
      if ({rb0.valid, rb0.busy} !== 2'b00) begin
        n_bad++; $display("FAIL bp_release: valid=%b busy=%b required 0 0", rb0.valid, rb0.busy);
      end
      step();
      n_cmp++;
      if (rb0.busy !== 1'b0) begin
        n_bad++; $display("FAIL bp_start_ignored: busy=%b required 0", rb0.busy);
      end
    end
    rb0.start = 1'b0;
  endtask

  task automatic test_single_glitch();
    int k; logic got; exp_t e;
    bank_mode = 1'b0; bus_force = 8'h3C; rb0.ready = 1'b1; rb0.addr = 2'd1; rb0.start = 1'b1;
    push_exp(8'h3D, 1'b0, 7);
    step(); rb0.start = 1'b0; k = 0;
    step(); k = 1;
    step(); k = 2; bus_force = 8'h3D;
    wait_valid0(30, k, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++; $display("FAIL glitch_valid: no valid within 30 cycles, required valid at 7"); sb.delete();
    end else begin
      e = sb.pop_front();
      if ({rb0.data_out, rb0.err} !== {e.data, e.err} || k !== e.lat) begin
        n_bad++;
        $display("FAIL glitch_result: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                 rb0.data_out, rb0.err, k, e.data, e.err, e.lat);
      end
    end
    step();
  endtask

  task automatic test_persistent();
    int k; int loads; logic got; exp_t e;
    bank_mode = 1'b0; bus_force = 8'h55; rb0.ready = 1'b1; rb0.addr = 2'd3; rb0.start = 1'b1;
    push_exp(8'h55, 1'b1, 13);
    step(); rb0.start = 1'b0; k = 0; loads = 0; got = 1'b0;
    bus_force = ~bus_force;
    while (!got && k < 40) begin
      step(); k++;
      if (rb0.cell_load) loads++;
      bus_force = ~bus_force;
      if (rb0.valid) got = 1'b1;
    end
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++; $display("FAIL unstable_valid: no valid within 40 cycles, required valid at 13"); sb.delete();
    end else begin
      e = sb.pop_front();
      if ({rb0.data_out, rb0.err} !== {e.data, e.err} || k !== e.lat) begin
        n_bad++;
        $display("FAIL unstable_result: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                 rb0.data_out, rb0.err, k, e.data, e.err, e.lat);
      end
    end
    n_cmp++;
    if (loads !== 4) begin
      n_bad++; $display("FAIL unstable_select_pulses: got %0d required 4", loads);
    end
    step();
  endtask

  task automatic test_bad_addr();
    exp_t e;
    rb1.ready = 1'b1; rb1.addr = 2'd3; rb1.start = 1'b1;
    push_exp(8'h00, 1'b1, 1);
    step(); rb1.start = 1'b0;
    step();
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL badaddr_sb: scoreboard empty, required one entry");
    end else begin
      e = sb.pop_front();
      if ({rb1.valid, rb1.data_out, rb1.err} !== {1'b1, e.data, e.err}) begin
        n_bad++;
        $display("FAIL badaddr_result: valid=%b data=%h err=%b required 1 %h %b",
                 rb1.valid, rb1.data_out, rb1.err, e.data, e.err);
      end
    end
    n_cmp++;
    if ({rb1.word_sel, rb1.cell_load, rb1.cell_en} !== 5'b0) begin
      n_bad++; $display("FAIL badaddr_strobes: sel=%b load=%b en=%b required 0", rb1.word_sel, rb1.cell_load, rb1.cell_en);
    end
    step();
    n_cmp++;
    if ({rb1.valid, rb1.busy} !== 2'b00) begin
      n_bad++; $display("FAIL badaddr_release: valid=%b busy=%b required 0 0", rb1.valid, rb1.busy);
    end
  endtask

  task automatic test_clear_mid_read();
    int k; logic got; exp_t e;
    bank_mode = 1'b1; rb0.ready = 1'b1; rb0.addr = 2'd1; rb0.start = 1'b1;
    step(); rb0.start = 1'b0;
    step(); Clear = 1'b1;
    step(); Clear = 1'b0;
    n_cmp++;
    if ({rb0.busy, rb0.valid, rb0.err, rb0.word_sel, rb0.cell_load, rb0.cell_en, rb0.data_out} !== 17'h0) begin
      n_bad++;
      $display("FAIL clear_mid: busy=%b valid=%b err=%b sel=%b load=%b en=%b data=%h required all 0",
               rb0.busy, rb0.valid, rb0.err, rb0.word_sel, rb0.cell_load, rb0.cell_en, rb0.data_out);
    end
    rb0.addr = 2'd0; rb0.start = 1'b1;
    push_exp(8'hC3, 1'b0, 4);
    step(); rb0.start = 1'b0; k = 0;
    wait_valid0(20, k, got);
    n_cmp++;
    if (!got || sb.size() == 0) begin
      n_bad++; $display("FAIL clear_reread_valid: no valid within 20 cycles, required valid at 4"); sb.delete();
    end else begin
      e = sb.pop_front();
      if ({rb0.data_out, rb0.err} !== {e.data, e.err} || k !== e.lat) begin
        n_bad++;
        $display("FAIL clear_reread: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                 rb0.data_out, rb0.err, k, e.data, e.err, e.lat);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    int k; logic got; exp_t e;
    bank_mode = 1'b1; rb0.ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rb0.addr = (r == 0) ? 2'd3 : 2'd0; rb0.start = 1'b1;
      push_exp((r == 0) ? 8'h0F : 8'hC3, 1'b0, 4);
      step(); rb0.start = 1'b0; k = 0;
      wait_valid0(20, k, got);
      n_cmp++;
      if (!got || sb.size() == 0) begin
        n_bad++; $display("FAIL b2b_valid%0d: no valid within 20 cycles, required valid at 4", r); sb.delete();
      end else begin
        e = sb.pop_front();
        if ({rb0.data_out, rb0.err} !== {e.data, e.err} || k !== e.lat) begin
          n_bad++;
          $display("FAIL b2b_result%0d: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                   r, rb0.data_out, rb0.err, k, e.data, e.err, e.lat);
        end
      end
      step();
    end
  endtask

  initial begin
    bank[0] = 8'hC3; bank[1] = 8'h5A; bank[2] = 8'hA5; bank[3] = 8'h0F;
    bank_mode = 1'b1; bus_force = 8'h00; Clear = 1'b1;
    rb0.start = 1'b0; rb0.addr = '0; rb0.ready = 1'b0;
    rb1.start = 1'b0; rb1.addr = '0; rb1.ready = 1'b0;
    test_reset();
    test_clean_read();
    test_backpressure();
    test_single_glitch();
    test_persistent();
    test_bad_addr();
    test_clear_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
